// File: rtl/rx_packetizer_if.sv
// Byte-stream input, command/word/packet-status outputs of the RX packetizer.
// slave = packetizer side, master = receiver/downstream side.
interface rx_packetizer_if;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned NB_W   = 3;

    logic [BYTE_W-1:0] rxd_data;
    logic              rxd_data_ready;
    logic              desync;
    logic [BYTE_W-1:0] cmd;
    logic [BYTE_W-1:0] cmd_len;
    logic              cmd_valid;
    logic [WORD_W-1:0] word_data;
    logic [NB_W-1:0]   word_nbytes;
    logic              word_last;
    logic              word_valid;
    logic              word_ready;
    logic              pkt_done;
    logic              pkt_ok;

    modport slave (
        input  rxd_data, rxd_data_ready, word_ready,
        output desync, cmd, cmd_len, cmd_valid,
               word_data, word_nbytes, word_last, word_valid,
               pkt_done, pkt_ok
    );

    modport master (
        output rxd_data, rxd_data_ready, word_ready,
        input  desync, cmd, cmd_len, cmd_valid,
               word_data, word_nbytes, word_last, word_valid,
               pkt_done, pkt_ok
    );
endinterface

// File: rtl/rx_packetizer.sv
// Parses CMD/LEN/payload/CHK byte packets into command info and little-endian
// 32-bit payload words, with XOR checksum, overflow tracking and inter-byte timeout.
module rx_packetizer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned TO_W           = 20
) (
    input  logic            clk,
    input  logic            reset,
    rx_packetizer_if.slave  bus
);
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned LANE_W = 2;
    localparam int unsigned NB_W   = 3;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_CMD, S_LEN, S_PAY, S_CHK} state_e;

    state_e              state_q, state_d;
    logic [BYTE_W-1:0]   cmd_q, cmd_d;
    logic [BYTE_W-1:0]   len_q, len_d;
    logic [BYTE_W-1:0]   rem_q, rem_d;
    logic [BYTE_W-1:0]   xor_q, xor_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [WORD_W-1:0]   asm_q, asm_d;
    logic                ovf_q, ovf_d;
    logic [TO_W-1:0]     to_q, to_d;

    logic                cmd_valid_q, cmd_valid_d;
    logic                desync_q, desync_d;
    logic                pkt_done_q, pkt_done_d;
    logic                pkt_ok_q, pkt_ok_d;
    logic [WORD_W-1:0]   word_data_q, word_data_d;
    logic [NB_W-1:0]     word_nbytes_q, word_nbytes_d;
    logic                word_last_q, word_last_d;
    logic                word_valid_q, word_valid_d;

    logic                strobe_c;
    logic                timeout_c;
    logic                word_done_c;
    logic                slot_blocked_c;
    logic [WORD_W-1:0]   lane_word_c;
    logic [TO_W-1:0]     to_inc_c;

    assign strobe_c       = bus.rxd_data_ready;
    assign to_inc_c       = to_q + TO_W'(1);
    // Fires so that pkt_done lands exactly TIMEOUT_CYCLES cycles after the last byte.
    assign timeout_c      = !strobe_c && (state_q != S_CMD) && (to_inc_c == TO_LAST);
    assign lane_word_c    = asm_q | (WORD_W'(bus.rxd_data) << {lane_q, 3'b000});
    assign word_done_c    = (lane_q == LANE_W'(3)) || (rem_q == BYTE_W'(1));
    assign slot_blocked_c = word_valid_q && !bus.word_ready;

    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        len_d         = len_q;
        rem_d         = rem_q;
        xor_d         = xor_q;
        lane_d        = lane_q;
        asm_d         = asm_q;
        ovf_d         = ovf_q;
        cmd_valid_d   = 1'b0;
        desync_d      = 1'b0;
        pkt_done_d    = 1'b0;
        pkt_ok_d      = 1'b0;
        word_data_d   = word_data_q;
        word_nbytes_d = word_nbytes_q;
        word_last_d   = word_last_q;
        word_valid_d  = slot_blocked_c;
        to_d          = (strobe_c || state_q == S_CMD) ? '0 : to_inc_c;

        unique case (state_q)
            S_CMD: begin
                if (strobe_c) begin
                    cmd_d   = bus.rxd_data;
                    xor_d   = bus.rxd_data;
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (strobe_c) begin
                    len_d       = bus.rxd_data;
                    rem_d       = bus.rxd_data;
                    xor_d       = xor_q ^ bus.rxd_data;
                    lane_d      = '0;
                    asm_d       = '0;
                    cmd_valid_d = 1'b1;
                    state_d     = (bus.rxd_data == '0) ? S_CHK : S_PAY;
                end
            end
            S_PAY: begin
                if (strobe_c) begin
                    xor_d = xor_q ^ bus.rxd_data;
                    rem_d = rem_q - BYTE_W'(1);
                    if (word_done_c) begin
                        asm_d  = '0;
                        lane_d = '0;
                        // Output slot still owned by downstream: drop the word.
                        if (slot_blocked_c) begin
                            ovf_d = 1'b1;
                        end else begin
                            word_data_d   = lane_word_c;
                            word_nbytes_d = NB_W'(lane_q) + NB_W'(1);
                            word_last_d   = (rem_q == BYTE_W'(1));
                            word_valid_d  = 1'b1;
                        end
                    end else begin
                        asm_d  = lane_word_c;
                        lane_d = lane_q + LANE_W'(1);
                    end
                    if (rem_q == BYTE_W'(1)) begin
                        state_d = S_CHK;
                    end
                end
            end
            S_CHK: begin
                if (strobe_c) begin
                    pkt_done_d = 1'b1;
                    pkt_ok_d   = (bus.rxd_data == xor_q) && !ovf_q;
                    desync_d   = (bus.rxd_data != xor_q);
                    ovf_d      = 1'b0;
                    state_d    = S_CMD;
                end
            end
            default: state_d = S_CMD;
        endcase

        // Abort leaves any already-presented word untouched.
        if (timeout_c) begin
            pkt_done_d = 1'b1;
            pkt_ok_d   = 1'b0;
            desync_d   = 1'b1;
            asm_d      = '0;
            lane_d     = '0;
            ovf_d      = 1'b0;
            to_d       = '0;
            state_d    = S_CMD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_CMD;
            cmd_q         <= '0;
            len_q         <= '0;
            rem_q         <= '0;
            xor_q         <= '0;
            lane_q        <= '0;
            asm_q         <= '0;
            ovf_q         <= 1'b0;
            to_q          <= '0;
            cmd_valid_q   <= 1'b0;
            desync_q      <= 1'b0;
            pkt_done_q    <= 1'b0;
            pkt_ok_q      <= 1'b0;
            word_data_q   <= '0;
            word_nbytes_q <= '0;
            word_last_q   <= 1'b0;
            word_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            len_q         <= len_d;
            rem_q         <= rem_d;
            xor_q         <= xor_d;
            lane_q        <= lane_d;
            asm_q         <= asm_d;
            ovf_q         <= ovf_d;
            to_q          <= to_d;
            cmd_valid_q   <= cmd_valid_d;
            desync_q      <= desync_d;
            pkt_done_q    <= pkt_done_d;
            pkt_ok_q      <= pkt_ok_d;
            word_data_q   <= word_data_d;
            word_nbytes_q <= word_nbytes_d;
            word_last_q   <= word_last_d;
            word_valid_q  <= word_valid_d;
        end
    end

    assign bus.cmd         = cmd_q;
    assign bus.cmd_len     = len_q;
    assign bus.cmd_valid   = cmd_valid_q;
    assign bus.desync      = desync_q;
    assign bus.pkt_done    = pkt_done_q;
    assign bus.pkt_ok      = pkt_ok_q;
    assign bus.word_data   = word_data_q;
    assign bus.word_nbytes = word_nbytes_q;
    assign bus.word_last   = word_last_q;
    assign bus.word_valid  = word_valid_q;
endmodule

// File: tb/tb_rx_packetizer.sv
// Scoreboard bench for rx_packetizer: directed packets plus randomized traffic
// checked against a packet-level reference model.
module tb_rx_packetizer;
    localparam int unsigned TO = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rx_packetizer_if bus();

    rx_packetizer #(.TIMEOUT_CYCLES(TO), .TO_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct { logic [7:0] cmd; logic [7:0] len; int cyc; } cmd_exp_t;
    typedef struct { logic [31:0] data; logic [2:0] nb; logic last; } word_exp_t;
    typedef struct { logic ok; logic desync; int cyc; } done_exp_t;

    cmd_exp_t  exp_cmd_q[$];
    word_exp_t exp_word_q[$];
    done_exp_t exp_done_q[$];
    logic [7:0] pl_q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int ready_mode = 1;   // 0 = hold low, 1 = hold high, 2 = random

    bit        cw_pending = 0;
    word_exp_t cw_word;
    bit        slot_full = 0;
    bit        pkt_ovf   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=pulse required=none (cycle %0d)", name, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // word_ready driver
    initial begin
        bus.word_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.word_ready = 1'b0;
                1:       bus.word_ready = 1'b1;
                default: bus.word_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // One-deep output slot: a completed word is dropped only if the slot is
    // still held and not being accepted on that edge.
    initial begin
        bit acc;
        forever begin
            @(posedge clk);
            if (reset) begin
                cw_pending = 0;
                slot_full  = 0;
            end else begin
                acc = slot_full && bus.word_ready;
                if (cw_pending) begin
                    cw_pending = 0;
                    if (slot_full && !acc) begin
                        pkt_ovf = 1;
                    end else begin
                        exp_word_q.push_back(cw_word);
                        slot_full = 1;
                    end
                end else if (acc) begin
                    slot_full = 0;
                end
            end
        end
    end

    // Monitor
    initial begin
        cmd_exp_t  ce;
        word_exp_t we, held;
        done_exp_t de;
        bit        holding;
        holding = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                holding = 0;
            end else begin
                if (bus.cmd_valid) begin
                    if (exp_cmd_q.size() == 0) unexpected("cmd_valid_unexpected");
                    else begin
                        ce = exp_cmd_q.pop_front();
                        chk("cmd", 32'(bus.cmd), 32'(ce.cmd));
                        chk("cmd_len", 32'(bus.cmd_len), 32'(ce.len));
                        chk("cmd_valid_cycle", cyc, ce.cyc);
                    end
                end
                if (bus.word_valid) begin
                    if (holding) begin
                        chk("word_hold_data", bus.word_data, held.data);
                        chk("word_hold_nbytes", 32'(bus.word_nbytes), 32'(held.nb));
                        chk("word_hold_last", 32'(bus.word_last), 32'(held.last));
                    end
                    if (bus.word_ready) begin
                        holding = 0;
                        if (exp_word_q.size() == 0) unexpected("word_unexpected");
                        else begin
                            we = exp_word_q.pop_front();
                            chk("word_data", bus.word_data, we.data);
                            chk("word_nbytes", 32'(bus.word_nbytes), 32'(we.nb));
                            chk("word_last", 32'(bus.word_last), 32'(we.last));
                        end
                    end else begin
                        holding = 1;
                        held = '{bus.word_data, bus.word_nbytes, bus.word_last};
                    end
                end else begin
                    holding = 0;
                end
                if (bus.pkt_done) begin
                    if (exp_done_q.size() == 0) unexpected("pkt_done_unexpected");
                    else begin
                        de = exp_done_q.pop_front();
                        chk("pkt_ok", 32'(bus.pkt_ok), 32'(de.ok));
                        chk("desync", 32'(bus.desync), 32'(de.desync));
                        chk("pkt_done_cycle", cyc, de.cyc);
                    end
                end else if (bus.desync) begin
                    unexpected("desync_without_pkt_done");
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_byte(input logic [7:0] b);
        bus.rxd_data       = b;
        bus.rxd_data_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rxd_data_ready = 1'b0;
        bus.rxd_data       = 8'($urandom);
        idle($urandom_range(0, 2));
    endtask

    // Sends CMD, LEN=pl_q.size(), pl_q, CHK (true XOR unless force_chk).
    task automatic send_packet(input logic [7:0] c, input bit force_chk, input logic [7:0] chk_val);
        logic [7:0]  len, x, cb;
        logic [31:0] acc;
        int          n;
        n   = pl_q.size();
        len = 8'(n);
        x   = c ^ len;
        drive_byte(c);
        exp_cmd_q.push_back('{c, len, cyc + 1});
        drive_byte(len);
        acc = '0;
        for (int i = 0; i < n; i++) begin
            x   = x ^ pl_q[i];
            acc = acc | (32'(pl_q[i]) << (8 * (i % 4)));
            if ((i % 4) == 3 || i == n - 1) begin
                cw_word    = '{acc, 3'((i % 4) + 1), (i == n - 1)};
                cw_pending = 1;
                acc        = '0;
            end
            drive_byte(pl_q[i]);
        end
        cb = force_chk ? chk_val : x;
        exp_done_q.push_back('{(cb == x) && !pkt_ovf, (cb != x), cyc + 1});
        pkt_ovf = 0;
        drive_byte(cb);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_cmd"}, 32'(bus.cmd), 0);
        chk({tag, "_cmd_len"}, 32'(bus.cmd_len), 0);
        chk({tag, "_cmd_valid"}, 32'(bus.cmd_valid), 0);
        chk({tag, "_word_data"}, bus.word_data, 0);
        chk({tag, "_word_nbytes"}, 32'(bus.word_nbytes), 0);
        chk({tag, "_word_last"}, 32'(bus.word_last), 0);
        chk({tag, "_word_valid"}, 32'(bus.word_valid), 0);
        chk({tag, "_pkt_done"}, 32'(bus.pkt_done), 0);
        chk({tag, "_pkt_ok"}, 32'(bus.pkt_ok), 0);
        chk({tag, "_desync"}, 32'(bus.desync), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        bus.rxd_data       = '0;
        bus.rxd_data_ready = 1'b0;

        @(posedge clk);
        #2;
        check_outputs_zero("reset");
        idle(2);
        reset = 1'b0;
        idle(2);

        // Two-word packet, correct checksum
        pl_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        send_packet(8'h01, 0, 8'h00);
        idle(3);

        // Zero-length packet
        pl_q = {};
        send_packet(8'h02, 1, 8'h02);
        idle(3);

        // Same payload, bad checksum
        pl_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        send_packet(8'h01, 1, 8'h00);
        idle(3);

        // Downstream stalled for a 10-byte payload
        ready_mode = 0;
        idle(2);
        pl_q = {};
        for (int i = 0; i < 10; i++) pl_q.push_back(8'(8'h30 + i));
        send_packet(8'h05, 0, 8'h00);
        idle(4);
        ready_mode = 1;
        idle(4);

        // Inter-byte timeout after one payload byte
        drive_byte(8'h03);
        exp_cmd_q.push_back('{8'h03, 8'h04, cyc + 1});
        drive_byte(8'h04);
        exp_done_q.push_back('{1'b0, 1'b1, cyc + TO});
        drive_byte(8'h11);
        idle(TO + 4);
        pkt_ovf = 0;
        pl_q = '{8'h21, 8'h22, 8'h23};
        send_packet(8'h09, 0, 8'h00);
        idle(3);

        // Randomized traffic with random backpressure
        ready_mode = 2;
        for (int p = 0; p < 30; p++) begin
            pl_q = {};
            for (int i = 0; i < int'($urandom_range(0, 11)); i++) pl_q.push_back(8'($urandom));
            if ($urandom_range(0, 3) == 0) send_packet(8'($urandom), 1, 8'($urandom));
            else send_packet(8'($urandom), 0, 8'h00);
            idle($urandom_range(0, 3));
        end
        ready_mode = 1;
        idle(6);

        // Reset in the middle of a packet
        drive_byte(8'h07);
        exp_cmd_q.push_back('{8'h07, 8'h06, cyc + 1});
        drive_byte(8'h06);
        idle(2);
        reset = 1'b1;
        #1;
        check_outputs_zero("midreset");
        exp_word_q = {};
        exp_done_q = {};
        pkt_ovf    = 0;
        idle(2);
        reset = 1'b0;
        idle(2);
        pl_q = '{8'h5A, 8'hA5, 8'h0F, 8'hF0, 8'h77, 8'h88};
        send_packet(8'h0B, 0, 8'h00);

        idle(30);
        chk("cmd_queue_drained", exp_cmd_q.size(), 0);
        chk("word_queue_drained", exp_word_q.size(), 0);
        chk("done_queue_drained", exp_done_q.size(), 0);
        s = checks;
        $display("TB_RESULT checks=%0d failures=%0d", s, failures);
        $finish;
    end
endmodule
